// File: rtl/reg_wb_pkg.sv
// Shared types for the register-file writeback queue: default widths, queue entry, arbiter source.
package reg_wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

    function automatic wb_src_t other_src(input wb_src_t src);
        return (src == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/reg_wb_fifo.sv
// DEPTH-entry circular buffer of writeback entries; storage is exposed when WB_FORWARD_EN is defined.
module reg_wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    output entry_t           head,
    output logic [PTR_W:0]   count,
    output logic             full
`ifdef WB_FORWARD_EN
    ,
    output entry_t           entries [DEPTH],
    output logic [PTR_W-1:0] head_ptr
`endif
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + (PTR_W+1)'(1);
            else if (pop && !push)
                count <= count - (PTR_W+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; count alone decides which slots hold live data.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];
    assign full = (count == (PTR_W+1)'(DEPTH));

`ifdef WB_FORWARD_EN
    assign entries  = mem;
    assign head_ptr = rd_ptr;
`endif

endmodule

// File: rtl/reg_writeback_queue.sv
// Two-producer writeback queue feeding the register-file write port; round-robin arbiter, x0 filter.
// Define WB_FORWARD_EN to add the LOOKUP1/LOOKUP2 forwarding search ports.
module reg_writeback_queue
    import reg_wb_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter int  DATA_W = WB_DATA_W,
    parameter int  ADDR_W = WB_ADDR_W,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ALU_VALID,
    output logic              ALU_READY,
    input  logic [ADDR_W-1:0] ALU_ADDRESS,
    input  logic [DATA_W-1:0] ALU_DATA,
    input  logic              MEM_VALID,
    output logic              MEM_READY,
    input  logic [ADDR_W-1:0] MEM_ADDRESS,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              WRITE_ENABLE,
    output logic [ADDR_W-1:0] WRITE_ADDRESS,
    output logic [DATA_W-1:0] WRITE_DATA,
    output logic [CNT_W-1:0]  COUNT,
    output logic              EMPTY
`ifdef WB_FORWARD_EN
    ,
    input  logic [ADDR_W-1:0] LOOKUP1_ADDRESS,
    output logic              LOOKUP1_HIT,
    output logic [DATA_W-1:0] LOOKUP1_DATA,
    input  logic [ADDR_W-1:0] LOOKUP2_ADDRESS,
    output logic              LOOKUP2_HIT,
    output logic [DATA_W-1:0] LOOKUP2_DATA
`endif
);

    localparam int PTR_W = CNT_W - 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           push_entry;
    entry_t           head;
    logic             push;
    logic             pop;
    logic             full;
    logic [CNT_W-1:0] count;
    wb_src_t          rr;

`ifdef WB_FORWARD_EN
    entry_t           entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
`endif

    reg_wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .full       (full)
`ifdef WB_FORWARD_EN
        ,
        .entries    (entries),
        .head_ptr   (head_ptr)
`endif
    );

    // READY is a function of VALIDs, fullness and the RR pointer only, never of this cycle's pop.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        ALU_READY = 1'b0;
        MEM_READY = 1'b0;
        if (!full) begin
            if (ALU_VALID && MEM_VALID) begin
                ALU_READY = (rr == SRC_ALU);
                MEM_READY = (rr == SRC_MEM);
            end else begin
                ALU_READY = ALU_VALID;
                MEM_READY = MEM_VALID;
            end
        end
    end

    always_comb begin
        push_entry.addr = MEM_ADDRESS;
        push_entry.data = MEM_DATA;
        push            = MEM_READY && (MEM_ADDRESS != '0);
        if (ALU_READY) begin
            push_entry.addr = ALU_ADDRESS;
            push_entry.data = ALU_DATA;
            push            = (ALU_ADDRESS != '0);
        end
    end

    assign pop = (count != '0);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            rr <= SRC_ALU;
        else if (ALU_VALID && MEM_VALID && !full)
            rr <= other_src(rr);
    end

    // WRITE_ADDRESS/WRITE_DATA hold their last value while the queue is idle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WRITE_ENABLE  <= 1'b0;
            WRITE_ADDRESS <= '0;
            WRITE_DATA    <= '0;
        end else begin
            WRITE_ENABLE <= pop;
            if (pop) begin
                WRITE_ADDRESS <= head.addr;
                WRITE_DATA    <= head.data;
            end
        end
    end

    assign COUNT = count;
    assign EMPTY = (count == '0) && !WRITE_ENABLE;

`ifdef WB_FORWARD_EN
    // Oldest to newest: WRITE_* stage first, then queue head to tail; later matches override.
    function automatic logic [DATA_W:0] forward(input logic [ADDR_W-1:0] addr);
        logic             hit;
        logic [DATA_W-1:0] data;
        logic [PTR_W-1:0] idx;
        hit  = 1'b0;
        data = '0;
        if (addr != '0) begin
            if (WRITE_ENABLE && (WRITE_ADDRESS == addr)) begin
                hit  = 1'b1;
                data = WRITE_DATA;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_ptr + PTR_W'(i);
                if ((CNT_W'(i) < count) && (entries[idx].addr == addr)) begin
                    hit  = 1'b1;
                    data = entries[idx].data;
                end
            end
        end
        return {hit, data};
    endfunction

    always_comb begin
        {LOOKUP1_HIT, LOOKUP1_DATA} = forward(LOOKUP1_ADDRESS);
        {LOOKUP2_HIT, LOOKUP2_DATA} = forward(LOOKUP2_ADDRESS);
    end
`endif

endmodule
